// File: rtl/snake_sprite_rom_arbiter_pkg.sv
// Shared constants and types for the snake sprite ROM arbiter.
package snake_sprite_pkg;

  localparam int unsigned SPRITE_ADDR_W  = 8;
  localparam int unsigned SPRITE_DATA_W  = 16;
  localparam int unsigned SPRITE_NUM_REQ = 4;

  typedef logic [SPRITE_NUM_REQ-1:0] req_onehot_t;
  typedef logic [SPRITE_DATA_W-1:0]  sprite_word_t;

endpackage

// File: rtl/snake_sprite_rom_arbiter_if.sv
// Requester/ROM bus for the sprite ROM arbiter.
// Host write signals exist only when SNAKE_SPRITE_HOST_WRITE_EN is defined.
interface snake_sprite_rom_arbiter_if import snake_sprite_pkg::*; #(
  parameter int unsigned NUM_REQ = SPRITE_NUM_REQ,
  parameter int unsigned ADDR_W  = SPRITE_ADDR_W,
  parameter int unsigned DATA_W  = SPRITE_DATA_W
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         rom_address;
  logic                      rom_chipselect;
  logic                      rom_clken;
  logic [DATA_W-1:0]         rom_readdata;
`ifdef SNAKE_SPRITE_HOST_WRITE_EN
  logic                      host_write;
  logic [ADDR_W-1:0]         host_address;
  logic [DATA_W-1:0]         host_writedata;
  logic [BE_W-1:0]           host_byteenable;
  logic                      host_waitrequest;
  logic                      rom_write;
  logic [DATA_W-1:0]         rom_writedata;
  logic [BE_W-1:0]           rom_byteenable;
  logic                      rom_debugaccess;

  modport slave (
    input  req_valid, req_addr, rom_readdata,
           host_write, host_address, host_writedata, host_byteenable,
    output req_ready, rsp_valid, rsp_data, rom_address, rom_chipselect, rom_clken,
           host_waitrequest, rom_write, rom_writedata, rom_byteenable, rom_debugaccess
  );
  modport master (
    output req_valid, req_addr, rom_readdata,
           host_write, host_address, host_writedata, host_byteenable,
    input  req_ready, rsp_valid, rsp_data, rom_address, rom_chipselect, rom_clken,
           host_waitrequest, rom_write, rom_writedata, rom_byteenable, rom_debugaccess
  );
`else
  modport slave (
    input  req_valid, req_addr, rom_readdata,
    output req_ready, rsp_valid, rsp_data, rom_address, rom_chipselect, rom_clken
  );
  modport master (
    output req_valid, req_addr, rom_readdata,
    input  req_ready, rsp_valid, rsp_data, rom_address, rom_chipselect, rom_clken
  );
`endif

endinterface

// File: rtl/snake_rr_arbiter.sv
// Round-robin one-hot arbiter; pointer holds the index searched first and
// moves past the winner only when the grant is actually taken.
module snake_rr_arbiter import snake_sprite_pkg::*; #(
  parameter int unsigned NUM_REQ = SPRITE_NUM_REQ
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0] ptr_q, ptr_d, idx;
  logic            found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = PtrW'((32'(idx) + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/snake_sprite_rom_arbiter.sv
// Shares one single-port sprite ROM among NUM_REQ readers with fixed 2-cycle
// one-hot tagged responses. Define SNAKE_SPRITE_HOST_WRITE_EN for the host write path.
module snake_sprite_rom_arbiter import snake_sprite_pkg::*; #(
  parameter int unsigned NUM_REQ = SPRITE_NUM_REQ,
  parameter int unsigned ADDR_W  = SPRITE_ADDR_W,
  parameter int unsigned DATA_W  = SPRITE_DATA_W
) (
  input logic                      clk,
  input logic                      reset_n,
  snake_sprite_rom_arbiter_if.slave bus
);
  // Goes high one cycle after reset release; gates grants and drives clken.
  logic               active_q;
  logic [NUM_REQ-1:0] arb_req, grant, tag1_q, tag2_q;
  logic               rd_grant, host_grant, chipselect;
  logic [ADDR_W-1:0]  grant_addr, rom_addr, addr_hold_q;
  logic [DATA_W-1:0]  rsp_data_q;

`ifdef SNAKE_SPRITE_HOST_WRITE_EN
  logic host_won_q;

  // Host wins unless it also won last cycle while readers are waiting.
  assign host_grant = active_q & bus.host_write & ~(host_won_q & (|bus.req_valid));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_won_q <= 1'b0;
    end else begin
      host_won_q <= host_grant;
    end
  end

  assign bus.host_waitrequest = bus.host_write & ~host_grant;
  assign bus.rom_write        = host_grant;
  assign bus.rom_debugaccess  = host_grant;
  assign bus.rom_writedata    = bus.host_writedata;
  assign bus.rom_byteenable   = bus.host_byteenable;
`else
  assign host_grant = 1'b0;
`endif

  assign arb_req  = (active_q && !host_grant) ? bus.req_valid : '0;
  assign rd_grant = |grant;

  snake_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (arb_req),
    .advance (rd_grant),
    .grant   (grant)
  );

  always_comb begin
    grant_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    rom_addr = addr_hold_q;
    if (rd_grant) rom_addr = grant_addr;
`ifdef SNAKE_SPRITE_HOST_WRITE_EN
    if (host_grant) rom_addr = bus.host_address;
`endif
  end

  assign chipselect = rd_grant | host_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q    <= 1'b0;
      addr_hold_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      rsp_data_q  <= '0;
    end else begin
      active_q <= 1'b1;
      tag1_q   <= grant;
      tag2_q   <= tag1_q;
      if (chipselect) addr_hold_q <= rom_addr;
      // ROM q is valid the cycle after the access; capture it with its tag.
      if (|tag1_q) rsp_data_q <= bus.rom_readdata;
    end
  end

  assign bus.req_ready      = grant;
  assign bus.rsp_valid      = tag2_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rom_address    = rom_addr;
  assign bus.rom_chipselect = chipselect;
  assign bus.rom_clken      = active_q;

endmodule

// File: tb/tb_snake_sprite_rom_arbiter.sv
// Directed bench for snake_sprite_rom_arbiter with a behavioural 256x16 ROM.
module tb_snake_sprite_rom_arbiter;
  import snake_sprite_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  snake_sprite_rom_arbiter_if bus_if ();

  snake_sprite_rom_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // ROM: address registered on access, output unregistered.
  sprite_word_t mem [256];
  logic [7:0]   rom_addr_q;

  always @(posedge clk) begin
    if (bus_if.rom_clken && bus_if.rom_chipselect) begin
      rom_addr_q <= bus_if.rom_address;
`ifdef SNAKE_SPRITE_HOST_WRITE_EN
      if (bus_if.rom_write) begin
        if (bus_if.rom_byteenable[0]) mem[bus_if.rom_address][7:0]  <= bus_if.rom_writedata[7:0];
        if (bus_if.rom_byteenable[1]) mem[bus_if.rom_address][15:8] <= bus_if.rom_writedata[15:8];
      end
`endif
    end
  end

  assign bus_if.rom_readdata = mem[rom_addr_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [7:0] a);
    bus_if.req_addr[i*8 +: 8] = a;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a      = 8'(i);
      mem[i] = {a, ~a};
    end
    mem[8'h10] = 16'hBEEF;

    reset_n          = 1'b1;
    bus_if.req_valid = '0;
    bus_if.req_addr  = '0;
`ifdef SNAKE_SPRITE_HOST_WRITE_EN
    bus_if.host_write      = 1'b0;
    bus_if.host_address    = '0;
    bus_if.host_writedata  = '0;
    bus_if.host_byteenable = '0;
`endif
    #1;
    reset_n          = 1'b0;
    bus_if.req_valid = 4'hF;
    #2;
    chk("rst_ready", 32'(bus_if.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(bus_if.rsp_data), 32'h0);
    chk("rst_rom_address", 32'(bus_if.rom_address), 32'h0);
    chk("rst_chipselect", 32'(bus_if.rom_chipselect), 32'h0);
    chk("rst_clken", 32'(bus_if.rom_clken), 32'h0);
    repeat (2) cyc();
    reset_n          = 1'b1;
    bus_if.req_valid = '0;
    #1;
    chk("rel_clken", 32'(bus_if.rom_clken), 32'h0);
    cyc();
    chk("run_clken", 32'(bus_if.rom_clken), 32'h1);

    // Single read: requester 2 reads 0x10
    bus_if.req_valid = 4'b0100;
    set_addr(2, 8'h10);
    #1;
    chk("single_ready", 32'(bus_if.req_ready), 32'h4);
    chk("single_addr", 32'(bus_if.rom_address), 32'h10);
    chk("single_cs", 32'(bus_if.rom_chipselect), 32'h1);
    cyc();
    bus_if.req_valid = '0;
    #1;
    chk("single_t1_rsp", 32'(bus_if.rsp_valid), 32'h0);
    chk("single_t1_cs", 32'(bus_if.rom_chipselect), 32'h0);
    chk("single_t1_hold", 32'(bus_if.rom_address), 32'h10);
    cyc();
    chk("single_t2_rsp", 32'(bus_if.rsp_valid), 32'h4);
    chk("single_t2_data", 32'(bus_if.rsp_data), 32'hBEEF);
    cyc();
    chk("single_t3_rsp", 32'(bus_if.rsp_valid), 32'h0);

    // Requester 1 alone, back-to-back 0xFE, 0xFF, 0x00
    cyc();
    bus_if.req_valid = 4'b0010;
    set_addr(1, 8'hFE);
    #1;
    chk("b2b_ready0", 32'(bus_if.req_ready), 32'h2);
    chk("b2b_addr0", 32'(bus_if.rom_address), 32'hFE);
    cyc();
    set_addr(1, 8'hFF);
    #1;
    chk("b2b_ready1", 32'(bus_if.req_ready), 32'h2);
    cyc();
    set_addr(1, 8'h00);
    #1;
    chk("b2b_ready2", 32'(bus_if.req_ready), 32'h2);
    chk("b2b_rsp0", 32'(bus_if.rsp_valid), 32'h2);
    chk("b2b_data0", 32'(bus_if.rsp_data), 32'hFE01);
    cyc();
    bus_if.req_valid = '0;
    #1;
    chk("b2b_rsp1", 32'(bus_if.rsp_valid), 32'h2);
    chk("b2b_data1", 32'(bus_if.rsp_data), 32'hFF00);
    cyc();
    chk("b2b_rsp2", 32'(bus_if.rsp_valid), 32'h2);
    chk("b2b_data2", 32'(bus_if.rsp_data), 32'h00FF);
    cyc();
    chk("b2b_rsp_end", 32'(bus_if.rsp_valid), 32'h0);

    // Two reads in flight, then a reset pulse
    cyc();
    bus_if.req_valid = 4'b0001;
    set_addr(0, 8'h40);
    #1;
    chk("fl_ready0", 32'(bus_if.req_ready), 32'h1);
    cyc();
    bus_if.req_valid = 4'b0010;
    set_addr(1, 8'h41);
    #1;
    chk("fl_ready1", 32'(bus_if.req_ready), 32'h2);
    cyc();
    reset_n          = 1'b0;
    bus_if.req_valid = '0;
    #1;
    chk("fl_rst_rsp", 32'(bus_if.rsp_valid), 32'h0);
    chk("fl_rst_ready", 32'(bus_if.req_ready), 32'h0);
    cyc();
    reset_n          = 1'b1;
    bus_if.req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_addr(i, 8'(8'h40 + i));
    #1;
    chk("rr_r0_ready", 32'(bus_if.req_ready), 32'h0);
    chk("rr_r0_rsp", 32'(bus_if.rsp_valid), 32'h0);
    cyc();
    chk("rr_r1_ready", 32'(bus_if.req_ready), 32'h1);
    chk("rr_r1_addr", 32'(bus_if.rom_address), 32'h40);
    chk("rr_r1_rsp", 32'(bus_if.rsp_valid), 32'h0);
    cyc();
    chk("rr_r2_ready", 32'(bus_if.req_ready), 32'h2);
    chk("rr_r2_rsp", 32'(bus_if.rsp_valid), 32'h0);
    cyc();
    chk("rr_r3_ready", 32'(bus_if.req_ready), 32'h4);
    chk("rr_r3_rsp", 32'(bus_if.rsp_valid), 32'h1);
    chk("rr_r3_data", 32'(bus_if.rsp_data), 32'h40BF);
    cyc();
    chk("rr_r4_ready", 32'(bus_if.req_ready), 32'h8);
    chk("rr_r4_rsp", 32'(bus_if.rsp_valid), 32'h2);
    chk("rr_r4_data", 32'(bus_if.rsp_data), 32'h41BE);
    cyc();
    chk("rr_r5_ready", 32'(bus_if.req_ready), 32'h1);
    chk("rr_r5_rsp", 32'(bus_if.rsp_valid), 32'h4);
    chk("rr_r5_data", 32'(bus_if.rsp_data), 32'h42BD);
    cyc();
    bus_if.req_valid = '0;
    #1;
    chk("rr_r6_rsp", 32'(bus_if.rsp_valid), 32'h8);
    chk("rr_r6_data", 32'(bus_if.rsp_data), 32'h43BC);
    cyc();
    chk("rr_r7_rsp", 32'(bus_if.rsp_valid), 32'h1);
    chk("rr_r7_data", 32'(bus_if.rsp_data), 32'h40BF);
    cyc();
    chk("rr_r8_rsp", 32'(bus_if.rsp_valid), 32'h0);

`ifdef SNAKE_SPRITE_HOST_WRITE_EN
    // Host writes interleaved with a continuously valid requester 0
    cyc();
    bus_if.req_valid       = 4'b0001;
    set_addr(0, 8'h30);
    bus_if.host_write      = 1'b1;
    bus_if.host_address    = 8'h20;
    bus_if.host_writedata  = 16'h1234;
    bus_if.host_byteenable = 2'b11;
    #1;
    chk("hw0_wait", 32'(bus_if.host_waitrequest), 32'h0);
    chk("hw0_write", 32'(bus_if.rom_write), 32'h1);
    chk("hw0_debug", 32'(bus_if.rom_debugaccess), 32'h1);
    chk("hw0_addr", 32'(bus_if.rom_address), 32'h20);
    chk("hw0_ready", 32'(bus_if.req_ready), 32'h0);
    cyc();
    bus_if.host_address    = 8'h21;
    bus_if.host_writedata  = 16'hAB56;
    bus_if.host_byteenable = 2'b01;
    #1;
    chk("hw1_wait", 32'(bus_if.host_waitrequest), 32'h1);
    chk("hw1_ready", 32'(bus_if.req_ready), 32'h1);
    chk("hw1_write", 32'(bus_if.rom_write), 32'h0);
    cyc();
    chk("hw2_wait", 32'(bus_if.host_waitrequest), 32'h0);
    chk("hw2_ready", 32'(bus_if.req_ready), 32'h0);
    chk("hw2_addr", 32'(bus_if.rom_address), 32'h21);
    cyc();
    bus_if.host_write = 1'b0;
    set_addr(0, 8'h20);
    #1;
    chk("hw3_ready", 32'(bus_if.req_ready), 32'h1);
    chk("hw3_rsp", 32'(bus_if.rsp_valid), 32'h1);
    chk("hw3_data", 32'(bus_if.rsp_data), 32'h30CF);
    cyc();
    set_addr(0, 8'h21);
    #1;
    chk("hw4_ready", 32'(bus_if.req_ready), 32'h1);
    cyc();
    bus_if.req_valid = '0;
    #1;
    chk("hw5_rsp", 32'(bus_if.rsp_valid), 32'h1);
    chk("hw5_data", 32'(bus_if.rsp_data), 32'h1234);
    cyc();
    chk("hw6_rsp", 32'(bus_if.rsp_valid), 32'h1);
    chk("hw6_data", 32'(bus_if.rsp_data), 32'h2156);
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
